// File: rtl/mem_dp_slave.sv
// Dual-port memory slave with per-port read pipeline, write-response
// holder, range/illegal-request errors and port-A-wins write collisions.
module mem_dp_slave #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_a,
  input  logic                  rd_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic                  slv_rsp_a,
  output logic                  err_a,
  input  logic                  wr_b,
  input  logic                  rd_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  slv_rsp_b,
  output logic                  err_b
);
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int L  = RD_LATENCY;

  logic [1:0]    wr;
  logic [1:0]    rd;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];

  assign wr       = {wr_b, wr_a};
  assign rd       = {rd_b, rd_a};
  assign addr[0]  = addr_a;
  assign addr[1]  = addr_b;
  assign wdata[0] = wdata_a;
  assign wdata[1] = wdata_b;

  logic [DW-1:0] mem_q [MEM_SIZE];
  logic [DW-1:0] mem_d [MEM_SIZE];

  logic [1:0]    in_rng;
  logic [1:0]    wr_ok;
  logic [1:0]    rd_req;
  logic          coll;
  logic [1:0]    coll_err;
  logic [DW-1:0] rd_data [2];

  logic [L-1:0]  pv_q [2];
  logic [L-1:0]  pv_d [2];
  logic [L-1:0]  pe_q [2];
  logic [L-1:0]  pe_d [2];
  logic [DW-1:0] pd_q [2][L];
  logic [DW-1:0] pd_d [2][L];

  logic [1:0]    wv_q, wv_d;
  logic [1:0]    we_q, we_d;
  logic [1:0]    hv_q, hv_d;
  logic [1:0]    he_q, he_d;

  logic [1:0]    rsp;
  logic [1:0]    err;
  logic [DW-1:0] rdata [2];

  always_comb begin
    in_rng = '0;
    wr_ok  = '0;
    rd_req = '0;
    for (int p = 0; p < 2; p++) begin
      in_rng[p] = {1'b0, addr[p]} < (AW+1)'(MEM_SIZE);
      wr_ok[p]  = wr[p] & ~rd[p] & in_rng[p];
      rd_req[p] = rd[p] & ~wr[p];
    end
    coll     = wr_ok[0] & wr_ok[1] & (addr[0] == addr[1]);
    coll_err = {coll, 1'b0};
  end

  // Read-before-write: data comes from the pre-edge array contents
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      for (int i = 0; i < MEM_SIZE; i++) begin
        if (in_rng[p] && addr[p] == AW'(i)) rd_data[p] = mem_q[i];
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < MEM_SIZE; i++) begin
      if (wr_ok[1] && !coll && addr[1] == AW'(i)) mem_d[i] = wdata[1];
      if (wr_ok[0] && addr[0] == AW'(i)) mem_d[i] = wdata[0];
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      pv_d[p] = '0;
      pe_d[p] = '0;
      for (int s = 0; s < L; s++) pd_d[p][s] = '0;
      pv_d[p][0] = rd_req[p];
      pe_d[p][0] = ~in_rng[p];
      pd_d[p][0] = rd_data[p];
      for (int s = 1; s < L; s++) begin
        pv_d[p][s] = pv_q[p][s-1];
        pe_d[p][s] = pe_q[p][s-1];
        pd_d[p][s] = pd_q[p][s-1];
      end
    end
  end

  // Write-class responses yield to a due read and park in the holder
  always_comb begin
    wv_d = '0;
    we_d = '0;
    hv_d = hv_q;
    he_d = he_q;
    rsp  = '0;
    err  = '0;
    for (int p = 0; p < 2; p++) begin
      rdata[p] = '0;
      wv_d[p]  = wr[p];
      we_d[p]  = (wr[p] & rd[p]) | ~in_rng[p] | coll_err[p];
      if (pv_q[p][L-1]) begin
        if (wv_q[p]) begin
          if (hv_q[p]) begin
            he_d[p] = 1'b1;
          end else begin
            hv_d[p] = 1'b1;
            he_d[p] = we_q[p];
          end
        end
        rsp[p]   = 1'b1;
        err[p]   = pe_q[p][L-1];
        rdata[p] = pd_q[p][L-1];
      end else if (hv_q[p]) begin
        hv_d[p] = wv_q[p];
        he_d[p] = wv_q[p] & we_q[p];
        rsp[p]  = 1'b1;
        err[p]  = he_q[p];
      end else begin
        hv_d[p] = 1'b0;
        he_d[p] = 1'b0;
        rsp[p]  = wv_q[p];
        err[p]  = wv_q[p] & we_q[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_SIZE; i++) mem_q[i] <= '0;
      for (int p = 0; p < 2; p++) begin
        pv_q[p] <= '0;
        pe_q[p] <= '0;
        for (int s = 0; s < L; s++) pd_q[p][s] <= '0;
      end
      wv_q <= '0;
      we_q <= '0;
      hv_q <= '0;
      he_q <= '0;
    end else begin
      mem_q <= mem_d;
      pv_q  <= pv_d;
      pe_q  <= pe_d;
      pd_q  <= pd_d;
      wv_q  <= wv_d;
      we_q  <= we_d;
      hv_q  <= hv_d;
      he_q  <= he_d;
    end
  end

  assign slv_rsp_a = rsp[0];
  assign err_a     = err[0];
  assign rdata_a   = rdata[0];
  assign slv_rsp_b = rsp[1];
  assign err_b     = err[1];
  assign rdata_b   = rdata[1];

endmodule

// File: tb/tb_mem_dp_slave.sv
// Directed bench for mem_dp_slave at default parameters.
module tb_mem_dp_slave;
  logic        clk;
  logic        reset;
  logic        wr_a, rd_a, wr_b, rd_b;
  logic [7:0]  addr_a, addr_b;
  logic [31:0] wdata_a, wdata_b;
  logic [31:0] rdata_a, rdata_b;
  logic        slv_rsp_a, err_a, slv_rsp_b, err_b;

  int n_chk;
  int n_pass;

  mem_dp_slave dut (
    .clk(clk), .reset(reset),
    .wr_a(wr_a), .rd_a(rd_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .rdata_a(rdata_a), .slv_rsp_a(slv_rsp_a), .err_a(err_a),
    .wr_b(wr_b), .rd_b(rd_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .rdata_b(rdata_b), .slv_rsp_b(slv_rsp_b), .err_b(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_a = 0; rd_a = 0; addr_a = '0; wdata_a = '0;
    wr_b = 0; rd_b = 0; addr_b = '0; wdata_b = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (slv_rsp_a !== 1'b0 || err_a !== 1'b0 || rdata_a !== 32'h0)
      $display("FAIL reset_a rsp=%b err=%b rdata=%h want 0/0/0",
               slv_rsp_a, err_a, rdata_a);
    else n_pass++;
    n_chk++;
    if (slv_rsp_b !== 1'b0 || err_b !== 1'b0 || rdata_b !== 32'h0)
      $display("FAIL reset_b rsp=%b err=%b rdata=%h want 0/0/0",
               slv_rsp_b, err_b, rdata_b);
    else n_pass++;
  endtask

  task automatic test_write_read();
    wr_a = 1; addr_a = 8'd3; wdata_a = 32'hDEADBEEF;
    tick(); idle();
    n_chk++;
    if (slv_rsp_a !== 1'b1 || err_a !== 1'b0 || rdata_a !== 32'h0)
      $display("FAIL wr_rsp rsp=%b err=%b rdata=%h want 1/0/0",
               slv_rsp_a, err_a, rdata_a);
    else n_pass++;
    tick();
    rd_a = 1; addr_a = 8'd3;
    tick(); idle();
    n_chk++;
    if (slv_rsp_a !== 1'b0)
      $display("FAIL rd_early rsp=%b want 0", slv_rsp_a);
    else n_pass++;
    tick();
    n_chk++;
    if (slv_rsp_a !== 1'b1 || err_a !== 1'b0 || rdata_a !== 32'hDEADBEEF)
      $display("FAIL rd_rsp rsp=%b err=%b rdata=%h want 1/0/deadbeef",
               slv_rsp_a, err_a, rdata_a);
    else n_pass++;
    tick();
    n_chk++;
    if (slv_rsp_a !== 1'b0 || rdata_a !== 32'h0)
      $display("FAIL rd_single rsp=%b rdata=%h want 0/0", slv_rsp_a, rdata_a);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 18; i++) begin
      idle();
      if (i < 16) begin rd_b = 1; addr_b = 8'(i); end
      tick();
      n_chk++;
      if (i >= 1 && i <= 16) begin
        if (slv_rsp_b !== 1'b1 || err_b !== 1'b0 || rdata_b !== 32'h0)
          $display("FAIL b2b_%0d rsp=%b err=%b rdata=%h want 1/0/0",
                   i, slv_rsp_b, err_b, rdata_b);
        else n_pass++;
      end else begin
        if (slv_rsp_b !== 1'b0)
          $display("FAIL b2b_idle_%0d rsp=%b want 0", i, slv_rsp_b);
        else n_pass++;
      end
    end
    idle();
  endtask

  task automatic test_write_collision();
    wr_a = 1; addr_a = 8'd5; wdata_a = 32'h11111111;
    wr_b = 1; addr_b = 8'd5; wdata_b = 32'h22222222;
    tick(); idle();
    n_chk++;
    if (slv_rsp_a !== 1'b1 || err_a !== 1'b0)
      $display("FAIL coll_a rsp=%b err=%b want 1/0", slv_rsp_a, err_a);
    else n_pass++;
    n_chk++;
    if (slv_rsp_b !== 1'b1 || err_b !== 1'b1)
      $display("FAIL coll_b rsp=%b err=%b want 1/1", slv_rsp_b, err_b);
    else n_pass++;
    rd_b = 1; addr_b = 8'd5;
    tick(); idle(); tick();
    n_chk++;
    if (slv_rsp_b !== 1'b1 || rdata_b !== 32'h11111111)
      $display("FAIL coll_data rsp=%b rdata=%h want 1/11111111",
               slv_rsp_b, rdata_b);
    else n_pass++;
    tick();
  endtask

  task automatic test_read_write_same_edge();
    wr_a = 1; addr_a = 8'd7; wdata_a = 32'h12345678;
    tick(); idle(); tick();
    wr_a = 1; addr_a = 8'd7; wdata_a = 32'hAAAA0000;
    rd_b = 1; addr_b = 8'd7;
    tick(); idle();
    n_chk++;
    if (slv_rsp_a !== 1'b1 || err_a !== 1'b0)
      $display("FAIL rw_wr rsp=%b err=%b want 1/0", slv_rsp_a, err_a);
    else n_pass++;
    tick();
    n_chk++;
    if (slv_rsp_b !== 1'b1 || err_b !== 1'b0 || rdata_b !== 32'h12345678)
      $display("FAIL rw_old rsp=%b err=%b rdata=%h want 1/0/12345678",
               slv_rsp_b, err_b, rdata_b);
    else n_pass++;
    rd_b = 1; addr_b = 8'd7;
    tick(); idle(); tick();
    n_chk++;
    if (slv_rsp_b !== 1'b1 || rdata_b !== 32'hAAAA0000)
      $display("FAIL rw_new rsp=%b rdata=%h want 1/aaaa0000",
               slv_rsp_b, rdata_b);
    else n_pass++;
    tick();
  endtask

  task automatic test_write_then_read();
    wr_a = 1; addr_a = 8'd11; wdata_a = 32'hCAFE0011;
    tick();
    wr_a = 0; rd_a = 1; addr_a = 8'd11; wdata_a = '0;
    tick(); idle(); tick();
    n_chk++;
    if (slv_rsp_a !== 1'b1 || rdata_a !== 32'hCAFE0011)
      $display("FAIL wtr rsp=%b rdata=%h want 1/cafe0011", slv_rsp_a, rdata_a);
    else n_pass++;
    tick();
  endtask

  task automatic test_errors();
    rd_a = 1; addr_a = 8'd16;
    tick(); idle();
    n_chk++;
    if (slv_rsp_a !== 1'b0)
      $display("FAIL oor_rd_early rsp=%b want 0", slv_rsp_a);
    else n_pass++;
    tick();
    n_chk++;
    if (slv_rsp_a !== 1'b1 || err_a !== 1'b1 || rdata_a !== 32'h0)
      $display("FAIL oor_rd rsp=%b err=%b rdata=%h want 1/1/0",
               slv_rsp_a, err_a, rdata_a);
    else n_pass++;
    wr_a = 1; addr_a = 8'd200; wdata_a = 32'h55555555;
    tick(); idle();
    n_chk++;
    if (slv_rsp_a !== 1'b1 || err_a !== 1'b1)
      $display("FAIL oor_wr rsp=%b err=%b want 1/1", slv_rsp_a, err_a);
    else n_pass++;
    wr_a = 1; rd_a = 1; addr_a = 8'd2; wdata_a = 32'h77777777;
    tick(); idle();
    n_chk++;
    if (slv_rsp_a !== 1'b1 || err_a !== 1'b1 || rdata_a !== 32'h0)
      $display("FAIL illegal rsp=%b err=%b rdata=%h want 1/1/0",
               slv_rsp_a, err_a, rdata_a);
    else n_pass++;
    tick();
    rd_a = 1; addr_a = 8'd8;
    tick();
    rd_a = 1; addr_a = 8'd2;
    tick();
    rd_a = 1; addr_a = 8'd15;
    n_chk++;
    if (slv_rsp_a !== 1'b1 || err_a !== 1'b0 || rdata_a !== 32'h0)
      $display("FAIL no_alias rsp=%b err=%b rdata=%h want 1/0/0",
               slv_rsp_a, err_a, rdata_a);
    else n_pass++;
    tick();
    rd_a = 1; addr_a = 8'd255;
    n_chk++;
    if (slv_rsp_a !== 1'b1 || err_a !== 1'b0 || rdata_a !== 32'h0)
      $display("FAIL illegal_nowr rsp=%b err=%b rdata=%h want 1/0/0",
               slv_rsp_a, err_a, rdata_a);
    else n_pass++;
    tick(); idle();
    n_chk++;
    if (slv_rsp_a !== 1'b1 || err_a !== 1'b0)
      $display("FAIL top_legal rsp=%b err=%b want 1/0", slv_rsp_a, err_a);
    else n_pass++;
    tick();
    n_chk++;
    if (slv_rsp_a !== 1'b1 || err_a !== 1'b1 || rdata_a !== 32'h0)
      $display("FAIL max_addr rsp=%b err=%b rdata=%h want 1/1/0",
               slv_rsp_a, err_a, rdata_a);
    else n_pass++;
    tick();
  endtask

  task automatic test_write_hold();
    wr_a = 1; addr_a = 8'd9; wdata_a = 32'h5A5A5A5A;
    tick(); idle(); tick();
    rd_a = 1; addr_a = 8'd9;
    tick();
    rd_a = 0; wr_a = 1; addr_a = 8'd10; wdata_a = 32'h0BADF00D;
    n_chk++;
    if (slv_rsp_a !== 1'b0)
      $display("FAIL hold_idle rsp=%b want 0", slv_rsp_a);
    else n_pass++;
    tick(); idle();
    n_chk++;
    if (slv_rsp_a !== 1'b1 || err_a !== 1'b0 || rdata_a !== 32'h5A5A5A5A)
      $display("FAIL hold_rd rsp=%b err=%b rdata=%h want 1/0/5a5a5a5a",
               slv_rsp_a, err_a, rdata_a);
    else n_pass++;
    tick();
    n_chk++;
    if (slv_rsp_a !== 1'b1 || err_a !== 1'b0 || rdata_a !== 32'h0)
      $display("FAIL hold_wr rsp=%b err=%b rdata=%h want 1/0/0",
               slv_rsp_a, err_a, rdata_a);
    else n_pass++;
    tick();
    n_chk++;
    if (slv_rsp_a !== 1'b0)
      $display("FAIL hold_done rsp=%b want 0", slv_rsp_a);
    else n_pass++;
    rd_a = 1; addr_a = 8'd10;
    tick(); idle(); tick();
    n_chk++;
    if (slv_rsp_a !== 1'b1 || rdata_a !== 32'h0BADF00D)
      $display("FAIL hold_mem rsp=%b rdata=%h want 1/0badf00d",
               slv_rsp_a, rdata_a);
    else n_pass++;
    tick();
  endtask

  task automatic test_mid_reset();
    wr_a = 1; addr_a = 8'd3; wdata_a = 32'h13572468;
    tick(); idle(); tick();
    rd_a = 1; addr_a = 8'd3;
    tick(); idle();
    reset = 1;
    tick();
    reset = 0;
    n_chk++;
    if (slv_rsp_a !== 1'b0 || err_a !== 1'b0 || rdata_a !== 32'h0)
      $display("FAIL mrst_0 rsp=%b err=%b rdata=%h want 0/0/0",
               slv_rsp_a, err_a, rdata_a);
    else n_pass++;
    tick();
    n_chk++;
    if (slv_rsp_a !== 1'b0 || rdata_a !== 32'h0)
      $display("FAIL mrst_1 rsp=%b rdata=%h want 0/0", slv_rsp_a, rdata_a);
    else n_pass++;
    rd_a = 1; addr_a = 8'd3;
    tick(); idle();
    n_chk++;
    if (slv_rsp_a !== 1'b0)
      $display("FAIL mrst_2 rsp=%b want 0", slv_rsp_a);
    else n_pass++;
    tick();
    n_chk++;
    if (slv_rsp_a !== 1'b1 || err_a !== 1'b0 || rdata_a !== 32'h0)
      $display("FAIL mrst_mem rsp=%b err=%b rdata=%h want 1/0/0",
               slv_rsp_a, err_a, rdata_a);
    else n_pass++;
    tick();
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    idle();
    reset = 1;
    tick();
    tick();
    test_reset();
    test_write_read();
    test_back_to_back();
    test_write_collision();
    test_read_write_same_edge();
    test_write_then_read();
    test_errors();
    test_write_hold();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
